// File: rtl/deal_setup.sv
// Klondike deal: takes 52 shuffled cards and fills 7 tableau columns, then 24 talon slots.
// Optional duplicate/range checking is enabled with `define DEAL_DUP_CHECK_EN.
module deal_setup #(
  parameter int CARD_SIZE   = 7,
  parameter int NUM_COLS    = 7,
  parameter int TALON_CARDS = 24
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  card_in_valid,
  input  logic [5:0]                            card_in,
  output logic                                  card_in_ready,
  output logic [NUM_COLS*NUM_COLS*CARD_SIZE-1:0] tableau_piles,
  output logic [NUM_COLS*3-1:0]                 tableau_sizes,
  output logic [TALON_CARDS*CARD_SIZE-1:0]      talon_pile,
  output logic [4:0]                            talon_size,
  output logic                                  setup_ready,
  output logic                                  setup_error
);

  localparam logic [2:0] LAST_IDX   = 3'(NUM_COLS - 1);
  localparam logic [4:0] LAST_TALON = 5'(TALON_CARDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEAL_TAB, S_DEAL_TALON, S_DONE, S_ERROR
  } state_t;

  state_t state_reg, state_next;

  logic [CARD_SIZE-1:0] tab_reg   [NUM_COLS*NUM_COLS];
  logic [2:0]           sizes_reg [NUM_COLS];
  logic [CARD_SIZE-1:0] talon_reg [TALON_CARDS];
  logic [4:0]           talon_size_reg;
  logic [4:0]           talon_idx_reg;
  logic [2:0]           row_reg;
  logic [2:0]           col_reg;
  logic                 setup_ready_reg;

  logic       accept;
  logic       restart;
  logic       bad_card;
  logic [5:0] tab_idx;

  assign accept  = card_in_valid && card_in_ready;
  assign restart = start && (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERROR);
  assign tab_idx = 6'(int'(col_reg) * NUM_COLS + int'(row_reg));

`ifdef DEAL_DUP_CHECK_EN
  // Indexed directly by card id; only bits 1..52 are ever set.
  logic [63:0] seen_reg;
  logic        setup_error_reg;
  assign bad_card    = (card_in == 6'd0) || (card_in > 6'd52) || seen_reg[card_in];
  assign setup_error = setup_error_reg;
`else
  assign bad_card    = 1'b0;
  assign setup_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    card_in_ready = 1'b0;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_DEAL_TAB;
      S_DEAL_TAB: begin
        card_in_ready = 1'b1;
        if (accept) begin
          if (bad_card) state_next = S_ERROR;
          else if (row_reg == LAST_IDX && col_reg == LAST_IDX) state_next = S_DEAL_TALON;
        end
      end
      S_DEAL_TALON: begin
        card_in_ready = 1'b1;
        if (accept) begin
          if (bad_card) state_next = S_ERROR;
          else if (talon_idx_reg == LAST_TALON) state_next = S_DONE;
        end
      end
      S_DONE:  if (start) state_next = S_DEAL_TAB;
      S_ERROR: if (start) state_next = S_DEAL_TAB;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      for (int i = 0; i < NUM_COLS*NUM_COLS; i++) tab_reg[i] <= '0;
      for (int i = 0; i < NUM_COLS; i++) sizes_reg[i] <= '0;
      for (int i = 0; i < TALON_CARDS; i++) talon_reg[i] <= '0;
      talon_size_reg  <= '0;
      talon_idx_reg   <= '0;
      row_reg         <= '0;
      col_reg         <= '0;
      setup_ready_reg <= 1'b0;
`ifdef DEAL_DUP_CHECK_EN
      seen_reg        <= '0;
      setup_error_reg <= 1'b0;
`endif
    end else if (accept && !bad_card) begin
`ifdef DEAL_DUP_CHECK_EN
      seen_reg[card_in] <= 1'b1;
`endif
      if (state_reg == S_DEAL_TAB) begin
        // Top card of each column (diagonal) is dealt face-up.
        tab_reg[tab_idx]   <= CARD_SIZE'({(row_reg == col_reg), card_in});
        sizes_reg[col_reg] <= sizes_reg[col_reg] + 3'd1;
        if (col_reg == LAST_IDX) begin
          row_reg <= row_reg + 3'd1;
          col_reg <= row_reg + 3'd1;
        end else begin
          col_reg <= col_reg + 3'd1;
        end
      end else begin
        talon_reg[talon_idx_reg] <= CARD_SIZE'({1'b0, card_in});
        talon_size_reg           <= talon_size_reg + 5'd1;
        talon_idx_reg            <= talon_idx_reg + 5'd1;
        if (talon_idx_reg == LAST_TALON) setup_ready_reg <= 1'b1;
      end
    end
`ifdef DEAL_DUP_CHECK_EN
    else if (accept) begin
      setup_error_reg <= 1'b1;
    end
`endif
  end

  generate
    for (genvar gi = 0; gi < NUM_COLS*NUM_COLS; gi++) begin : g_tab
      assign tableau_piles[gi*CARD_SIZE +: CARD_SIZE] = tab_reg[gi];
    end
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_sizes
      assign tableau_sizes[gi*3 +: 3] = sizes_reg[gi];
    end
    for (genvar gi = 0; gi < TALON_CARDS; gi++) begin : g_talon
      assign talon_pile[gi*CARD_SIZE +: CARD_SIZE] = talon_reg[gi];
    end
  endgenerate

  assign talon_size  = talon_size_reg;
  assign setup_ready = setup_ready_reg;

endmodule

// File: tb/tb_deal_setup.sv
// Scoreboard bench for deal_setup: each issued deal pushes its expected final layout,
// a monitor pops and compares when setup_ready rises.
module tb_deal_setup;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         card_in_valid;
  logic [5:0]   card_in;
  logic         card_in_ready;
  logic [342:0] tableau_piles;
  logic [20:0]  tableau_sizes;
  logic [167:0] talon_pile;
  logic [4:0]   talon_size;
  logic         setup_ready;
  logic         setup_error;

  deal_setup dut (
    .clk(clk), .rst(rst), .start(start), .card_in_valid(card_in_valid),
    .card_in(card_in), .card_in_ready(card_in_ready),
    .tableau_piles(tableau_piles), .tableau_sizes(tableau_sizes),
    .talon_pile(talon_pile), .talon_size(talon_size),
    .setup_ready(setup_ready), .setup_error(setup_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [342:0] tab;
    logic [20:0]  sizes;
    logic [167:0] talon;
    logic [4:0]   tsize;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] stream [52];
  int         n_vec = 0;
  int         n_err = 0;
  int         deal_no = 0;
  int         lc;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference layout: rows top to bottom, columns left to right from the diagonal.
  function automatic exp_t build_expected();
    exp_t e;
    int   i;
    e = '0;
    i = 0;
    for (int r = 0; r < 7; r++)
      for (int c = r; c < 7; c++) begin
        e.tab[(c*7 + r)*7 +: 7] = {(c == r), stream[i]};
        e.sizes[c*3 +: 3]       = e.sizes[c*3 +: 3] + 3'd1;
        i++;
      end
    for (int k = 0; k < 24; k++) e.talon[k*7 +: 7] = {1'b0, stream[28 + k]};
    e.tsize = 5'd24;
    return e;
  endfunction

  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (setup_ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_ready: got setup_ready=1 expected no completed deal");
      end else begin
        e = exp_q.pop_front();
        deal_no++;
        check("tableau_piles", tableau_piles, e.tab);
        check("tableau_sizes", tableau_sizes, e.sizes);
        check("talon_pile", talon_pile, e.talon);
        check("talon_size", talon_size, e.tsize);
        $display("deal %0d complete at %0t: sizes=%o talon_size=%0d", deal_no, $time,
                 tableau_sizes, talon_size);
      end
    end
    prev_ready = setup_ready;
  end

  // Called at a negedge; returns at the following negedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int gap, input int n_cards, input int start_at, output int last_cyc);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    last_cyc = -1;
    while (i < n_cards && cyc < 400) begin
      card_in_valid = (gap == 0) || (cyc % 2 == 0);
      card_in       = stream[i];
      start         = (i == start_at) && card_in_valid;
      if (card_in_valid && card_in_ready) begin
        if (i == 51) check("ready_before_last", setup_ready, 0);
        i++;
        last_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    card_in_valid = 1'b0;
    start = 1'b0;
    if (i < n_cards) begin
      n_vec++;
      n_err++;
      $display("FAIL feed_timeout: got %0d accepts expected %0d", i, n_cards);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_tab"}, tableau_piles, 0);
    check({tag, "_sizes"}, tableau_sizes, 0);
    check({tag, "_talon"}, talon_pile, 0);
    check({tag, "_tsize"}, talon_size, 0);
    check({tag, "_ready"}, setup_ready, 0);
    check({tag, "_error"}, setup_error, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    card_in_valid = 1'b0;
    card_in = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    check("reset_card_in_ready", card_in_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    // Ascending ids, valid held high
    for (int i = 0; i < 52; i++) stream[i] = 6'(i + 1);
    exp_q.push_back(build_expected());
    pulse_start();
    feed(0, 52, -1, lc);
    check("last_accept_cycle", lc, 51);
    check("ready_after_last", setup_ready, 1);
    check("sizes_const", tableau_sizes, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1});
    check("col0_slot0", tableau_piles[6:0], 7'h41);
    check("col6_slot0", tableau_piles[42*7 +: 7], 7'h07);
    check("col6_slot6", tableau_piles[48*7 +: 7], 7'h5C);
    check("talon_slot0", talon_pile[6:0], 7'd29);
    check("talon_slot23", talon_pile[23*7 +: 7], 7'd52);
    check("talon_size_const", talon_size, 24);
    check("done_card_in_ready", card_in_ready, 0);

    // Restart from DONE clears on the start edge; then valid every other cycle
    exp_q.push_back(build_expected());
    pulse_start();
    check("restart_sizes", tableau_sizes, 0);
    check("restart_ready", setup_ready, 0);
    check("restart_talon", talon_pile, 0);
    feed(1, 52, -1, lc);
    check("gap_last_accept_cycle", lc, 102);
    check("gap_ready_cycle103", setup_ready, 1);

    // Descending ids with a start pulse at card 10 that must be ignored
    for (int i = 0; i < 52; i++) stream[i] = 6'(52 - i);
    exp_q.push_back(build_expected());
    pulse_start();
    feed(0, 52, 10, lc);
    check("midstart_ready", setup_ready, 1);

    // Reset after 30 accepts, then a fresh permuted deal
    pulse_start();
    feed(0, 30, -1, lc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("midreset");
    check("midreset_card_in_ready", card_in_ready, 0);
    for (int i = 0; i < 52; i++) stream[i] = 6'((i * 7) % 52 + 1);
    exp_q.push_back(build_expected());
    pulse_start();
    feed(0, 52, -1, lc);
    check("perm_ready", setup_ready, 1);

`ifdef DEAL_DUP_CHECK_EN
    // Card 5 repeated at positions 3 and 4
    stream[0] = 6'd1; stream[1] = 6'd2; stream[2] = 6'd3; stream[3] = 6'd5; stream[4] = 6'd5;
    pulse_start();
    feed(0, 5, -1, lc);
    check("dup_error", setup_error, 1);
    check("dup_card_in_ready", card_in_ready, 0);
    check("dup_sizes", tableau_sizes, {3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1});
    card_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    card_in_valid = 1'b0;
    check("dup_ready_low", setup_ready, 0);
    check("dup_sizes_hold", tableau_sizes, {3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1});

    // Out-of-range id first, then recovery
    stream[0] = 6'd53;
    pulse_start();
    feed(0, 1, -1, lc);
    check("range_error", setup_error, 1);
    check("range_sizes", tableau_sizes, 0);
    for (int i = 0; i < 52; i++) stream[i] = 6'(i + 1);
    exp_q.push_back(build_expected());
    pulse_start();
    check("recover_error_clear", setup_error, 0);
    feed(0, 52, -1, lc);
    check("recover_ready", setup_ready, 1);
    check("recover_no_error", setup_error, 0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
